// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: opcodes, FSM states,
// and the default operand-half width.
package mul_seq_ctrl_pkg;

  localparam int HALF_W_DEFAULT = 16;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/mul16_reg.sv
// Unsigned HALF_W x HALF_W multiplier with a single output register,
// clock enable and asynchronous clear; intended to map onto one DSP block.
module mul16_reg #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ce,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p <= '0;
    end else if (ce) begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply sequencer: four partial products through one
// registered 16x16 multiplier, then sign correction and word selection.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int                   HALF_W       = HALF_W_DEFAULT,
  parameter logic [2*HALF_W-1:0]  RESET_RESULT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [2*HALF_W-1:0]  in_src1,
  input  logic [2*HALF_W-1:0]  in_src2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*HALF_W-1:0]  out_result,
  output logic                 busy
);

  localparam int W = 2 * HALF_W;

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       op_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [2*W-1:0]   acc;

  logic [HALF_W-1:0] mul_a;
  logic [HALF_W-1:0] mul_b;
  logic [W-1:0]      prod;

  logic [1:0]       prev_idx;
  logic [2*W-1:0]   prod_ext;
  logic [2*W-1:0]   prod_shifted;
  logic [2*W-1:0]   acc_sum;
  logic [2*W-1:0]   acc_fix;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Index bit 1 picks the A half, bit 0 the B half: LL, LH, HL, HH.
  assign mul_a = idx[1] ? a_reg[W-1:HALF_W] : a_reg[HALF_W-1:0];
  assign mul_b = idx[0] ? b_reg[W-1:HALF_W] : b_reg[HALF_W-1:0];

  mul16_reg #(.HALF_W(HALF_W)) u_mul (
    .clk (clk),
    .clr (reset),
    .ce  (state == ST_ISSUE),
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod)
  );

  // The registered product belongs to the index issued one cycle earlier.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    prev_idx     = (state == ST_DRAIN) ? 2'd3 : idx - 2'd1;
    prod_ext     = {{W{1'b0}}, prod};
    prod_shifted = prod_ext;
    case (prev_idx)
      2'd0:    prod_shifted = prod_ext;
      2'd1,
      2'd2:    prod_shifted = prod_ext << HALF_W;
      default: prod_shifted = prod_ext << W;
    endcase
    acc_sum = acc + prod_shifted;

    acc_fix = acc_sum;
    if ((op_reg == OP_MULXSU || op_reg == OP_MULXSS) && a_reg[W-1]) begin
      acc_fix = acc_fix - {b_reg, {W{1'b0}}};
    end
    if (op_reg == OP_MULXSS && b_reg[W-1]) begin
      acc_fix = acc_fix - {a_reg, {W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      op_reg     <= OP_MUL;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_result <= RESET_RESULT;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg  <= in_src1;
            b_reg  <= in_src2;
            op_reg <= in_op;
            idx    <= 2'd0;
            acc    <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (idx != 2'd0) begin
            acc <= acc_sum;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          acc        <= acc_fix;
          out_result <= (op_reg == OP_MUL) ? acc_fix[W-1:0] : acc_fix[2*W-1:W];
          out_valid  <= 1'b1;
          state      <= ST_OUT;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, random ops
// against a plain-arithmetic model, and handshake/flush/reset sequences.
module tb_mul_seq_ctrl;
  import mul_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: full-width product of sign/zero-extended operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;
    ax = (op == OP_MULXSU || op == OP_MULXSS) ? {{32{a[31]}}, a} : {32'd0, a};
    bx = (op == OP_MULXSS) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ax * bx;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_bit("in_ready_before_accept", in_ready, 1'b1);
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_src1  = $urandom;
    in_src2  = $urandom;
    in_op    = 2'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_result(input string name, output logic [31:0] res);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = out_valid;
    end
    check_bit({name, "_valid"}, seen, 1'b1);
    check({name, "_latency"}, 32'(n), 32'd5);
    res = out_result;
  endtask

  task automatic take_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_bit({name, "_valid_cleared"}, out_valid, 1'b0);
    check_bit({name, "_idle_after"}, in_ready, 1'b1);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    issue(op, a, b);
    wait_result(name, res);
    check(name, res, exp);
    take_result(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] exp;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        seen;

    vecs[0] = '{"mul_ones",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[1] = '{"mulxuu_ones",   OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{"mulxss_ones",   OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{"mulxsu_ones",   OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{"mulxss_min",    OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[5] = '{"mulxuu_2p16",   OP_MULXUU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[6] = '{"mul_2p16",      OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[7] = '{"mul_3x5",       OP_MUL,    32'd3,         32'd5,         32'h0000_000F};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_MUL;
    in_src1   = '0;
    in_src2   = '0;
    out_ready = 1'b0;

    #1;
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check("reset_out_result", out_result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = (i % 8 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      run($sformatf("rand%0d", i), op, a, b, model(op, a, b));
    end

    // Backpressure: result held, new requests ignored until the handshake.
    a   = 32'hDEAD_BEEF;
    b   = 32'h1234_5678;
    exp = model(OP_MULXUU, a, b);
    issue(OP_MULXUU, a, b);
    wait_result("bp", res);
    check("bp_result", res, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = OP_MUL;
      in_src1  = $urandom;
      in_src2  = $urandom;
      @(posedge clk);
      @(negedge clk);
      check_bit("bp_hold_valid", out_valid, 1'b1);
      check_bit("bp_hold_in_ready", in_ready, 1'b0);
      check("bp_hold_result", out_result, exp);
    end
    @(negedge clk);
    in_op     = OP_MULXSU;
    in_src1   = 32'hF000_0001;
    in_src2   = 32'h0000_0100;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_bit("bp_release_valid", out_valid, 1'b0);
    check_bit("bp_no_same_cycle_accept", busy, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("bp_next_accepted", busy, 1'b1);
    wait_result("bp_next", res);
    check("bp_next_result", res, model(OP_MULXSU, 32'hF000_0001, 32'h0000_0100));
    take_result("bp_next");

    // Flush while ISSUE is on index 2.
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_bit("flush_idle", in_ready, 1'b1);
    check_bit("flush_busy", busy, 1'b0);
    seen = out_valid;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check_bit("flush_no_out_valid", seen, 1'b0);

    // Flush with a request in IDLE drops the request.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check_bit("flush_drops_request", busy, 1'b0);
    run("post_flush_mul_3x5", OP_MUL, 32'd3, 32'd5, 32'h0000_000F);

    // Reset asserted during DRAIN takes effect without a clock edge.
    issue(OP_MULXSS, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_bit("rst_drain_out_valid", out_valid, 1'b0);
    check_bit("rst_drain_in_ready", in_ready, 1'b1);
    check("rst_drain_out_result", out_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    a = $urandom;
    b = $urandom;
    run("post_reset", OP_MULXSU, a, b, model(OP_MULXSU, a, b));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
